// File: rtl/cat_trap_pkg.sv
// rtl/cat_trap_pkg.sv - shared cell codes, game states and probe directions for the Cat Trap engine
//
// Purpose : Definitions shared by the engine, its sub-modules and the renderer side.
// Contents: cell codes EMPTY/BLOCK/CAT/OFF, state_t game states, neighbour probe order.
package cat_trap_pkg;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BLOCK = 2'd1;
   localparam logic [1:0] CAT   = 2'd2;
   localparam logic [1:0] OFF   = 2'd3;

   typedef enum logic [2:0] {
      CLEAR = 3'd0,
      IDLE  = 3'd1,
      PLAY  = 3'd2,
      MOVE  = 3'd3,
      WIN   = 3'd4,
      LOSE  = 3'd5
   } state_t;

   // The cat tries its neighbours in this order, one per MOVE cycle.
   localparam logic [1:0] DIR_DOWN  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - single-bit rising-edge detector for debounced button levels
//
// Purpose: Pulses Rise for one cycle when Din is high and was low last cycle.
// Ports  : Clk, Reset (async, active-high), Din (level in), Rise (edge pulse out).
module btn_edge (
   input  logic Clk,
   input  logic Reset,
   input  logic Din,
   output logic Rise
);

   logic hist;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) hist <= 1'b0;
      else       hist <= Din;
   end

   assign Rise = Din & ~hist;

endmodule

// File: rtl/cat_trap_engine.sv
// rtl/cat_trap_engine.sv - Cat Trap game engine: board storage, cat movement and game sequencing
//
// Purpose: ROWS x COLS board that clears itself one cell per clock, accepts block
//          placements on button edges and moves the cat one probe per cycle.
// Ports  : Clk, Reset (async, active-high); Start/Place button levels; Sel_row/Sel_col
//          placement target; Rd_row/Rd_col -> Rd_cell combinational renderer read port;
//          State, Cat_row/Cat_col, Move_count, Busy status outputs.
module cat_trap_engine
   import cat_trap_pkg::*;
#(
   parameter int ROWS  = 6,
   parameter int COLS  = 7,
   parameter int CNT_W = 8,
   parameter int ROW_W = $clog2(ROWS),
   parameter int COL_W = $clog2(COLS)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Place,
   input  logic [ROW_W-1:0] Sel_row,
   input  logic [COL_W-1:0] Sel_col,
   input  logic [ROW_W-1:0] Rd_row,
   input  logic [COL_W-1:0] Rd_col,
   output logic [1:0]       Rd_cell,
   output logic [2:0]       State,
   output logic [ROW_W-1:0] Cat_row,
   output logic [COL_W-1:0] Cat_col,
   output logic [CNT_W-1:0] Move_count,
   output logic             Busy
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MID  = ROW_W'(ROWS / 2);
   localparam logic [COL_W-1:0] COL_MID  = COL_W'(COLS / 2);

   logic start_rise, place_rise;

   btn_edge u_start_edge (.Clk(Clk), .Reset(Reset), .Din(Start), .Rise(start_rise));
   btn_edge u_place_edge (.Clk(Clk), .Reset(Reset), .Din(Place), .Rise(place_rise));

   // Board storage is deliberately unreset; CLEAR sweeps it instead.
   logic [1:0] board [ROWS][COLS];

   state_t           state, state_n;
   logic [ROW_W-1:0] clr_row, clr_row_n, cat_row_n, nb_row, wa_row, wb_row;
   logic [COL_W-1:0] clr_col, clr_col_n, cat_col_n, nb_col, wa_col, wb_col;
   logic [CNT_W-1:0] move_count_n;
   logic [1:0]       dir, dir_n, wa_data, nb_cell, sel_cell;
   logic             we_a, we_b, rd_ok, sel_ok, place_ok, nb_border;

   assign rd_ok   = (Rd_row <= ROW_LAST) && (Rd_col <= COL_LAST);
   assign Rd_cell = rd_ok ? board[Rd_row][Rd_col] : OFF;

   assign sel_ok   = (Sel_row <= ROW_LAST) && (Sel_col <= COL_LAST);
   assign sel_cell = sel_ok ? board[Sel_row][Sel_col] : OFF;
   assign place_ok = place_rise && sel_ok && (sel_cell == EMPTY);

   // Neighbour under probe; the cat is interior in PLAY/MOVE so no wrap occurs.
   always_comb begin
      nb_row = Cat_row;
      nb_col = Cat_col;
      case (dir)
         DIR_DOWN:  nb_row = Cat_row + ROW_W'(1);
         DIR_RIGHT: nb_col = Cat_col + COL_W'(1);
         DIR_UP:    nb_row = Cat_row - ROW_W'(1);
         default:   nb_col = Cat_col - COL_W'(1);
      endcase
   end

   assign nb_cell   = board[nb_row][nb_col];
   assign nb_border = (nb_row == '0) || (nb_row == ROW_LAST) ||
                      (nb_col == '0) || (nb_col == COL_LAST);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= CLEAR;
         clr_row    <= '0;
         clr_col    <= '0;
         Cat_row    <= ROW_MID;
         Cat_col    <= COL_MID;
         Move_count <= '0;
         dir        <= DIR_DOWN;
      end else begin
         state      <= state_n;
         clr_row    <= clr_row_n;
         clr_col    <= clr_col_n;
         Cat_row    <= cat_row_n;
         Cat_col    <= cat_col_n;
         Move_count <= move_count_n;
         dir        <= dir_n;
      end
   end

   // Two write ports: port A clears/places/vacates, port B writes the cat.
   // Port B is applied last so it wins if both hit the same cell.
   always_comb begin
      state_n      = state;
      clr_row_n    = clr_row;
      clr_col_n    = clr_col;
      cat_row_n    = Cat_row;
      cat_col_n    = Cat_col;
      move_count_n = Move_count;
      dir_n        = dir;
      we_a         = 1'b0;
      wa_row       = clr_row;
      wa_col       = clr_col;
      wa_data      = EMPTY;
      we_b         = 1'b0;
      wb_row       = ROW_MID;
      wb_col       = COL_MID;
      case (state)
         CLEAR: begin
            we_a = 1'b1;
            if (clr_col == COL_LAST) begin
               clr_col_n = '0;
               clr_row_n = clr_row + ROW_W'(1);
            end else begin
               clr_col_n = clr_col + COL_W'(1);
            end
            if ((clr_row == ROW_LAST) && (clr_col == COL_LAST)) begin
               clr_row_n    = '0;
               we_b         = 1'b1;
               cat_row_n    = ROW_MID;
               cat_col_n    = COL_MID;
               move_count_n = '0;
               state_n      = IDLE;
            end
         end
         IDLE: begin
            if (start_rise) begin
               state_n = PLAY;
            end else if (place_ok) begin
               we_a    = 1'b1;
               wa_row  = Sel_row;
               wa_col  = Sel_col;
               wa_data = BLOCK;
            end
         end
         PLAY: begin
            if (place_ok) begin
               we_a    = 1'b1;
               wa_row  = Sel_row;
               wa_col  = Sel_col;
               wa_data = BLOCK;
               if (Move_count != '1) move_count_n = Move_count + CNT_W'(1);
               state_n = MOVE;
               dir_n   = DIR_DOWN;
            end
         end
         MOVE: begin
            if (nb_cell == EMPTY) begin
               we_a      = 1'b1;
               wa_row    = Cat_row;
               wa_col    = Cat_col;
               wa_data   = EMPTY;
               we_b      = 1'b1;
               wb_row    = nb_row;
               wb_col    = nb_col;
               cat_row_n = nb_row;
               cat_col_n = nb_col;
               state_n   = nb_border ? LOSE : PLAY;
            end else if (dir == DIR_LEFT) begin
               state_n = WIN;
            end else begin
               dir_n = dir + 2'd1;
            end
         end
         WIN, LOSE: begin
            if (start_rise) state_n = CLEAR;
         end
         default: state_n = CLEAR;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (we_a) board[wa_row][wa_col] <= wa_data;
      if (we_b) board[wb_row][wb_col] <= CAT;
   end

   assign State = state;
   assign Busy  = (state == CLEAR) || (state == MOVE);

endmodule

// File: tb/tb_cat_trap_engine.sv
// tb/tb_cat_trap_engine.sv - self-checking bench for cat_trap_engine (default 6x7 board)
module tb_cat_trap_engine;
   import cat_trap_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Place = 1'b0;
   logic [2:0] Sel_row = '0, Sel_col = '0, Rd_row = '0, Rd_col = '0;
   logic [1:0] Rd_cell;
   logic [2:0] State, Cat_row, Cat_col;
   logic [7:0] Move_count;
   logic       Busy;

   cat_trap_engine dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Place(Place),
      .Sel_row(Sel_row), .Sel_col(Sel_col), .Rd_row(Rd_row), .Rd_col(Rd_col),
      .Rd_cell(Rd_cell), .State(State), .Cat_row(Cat_row), .Cat_col(Cat_col),
      .Move_count(Move_count), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0] r, c, st, cr, cc;
      logic [7:0] mc;
   } step_t;

   step_t sb[$];

   function automatic step_t mk(int r, int c, int st, int cr, int cc, int mc);
      step_t s;
      s.r = 3'(r); s.c = 3'(c); s.st = 3'(st);
      s.cr = 3'(cr); s.cc = 3'(cc); s.mc = 8'(mc);
      return s;
   endfunction

   task automatic press_place(input logic [2:0] r, input logic [2:0] c);
      Sel_row = r; Sel_col = c; Place = 1'b1;
      @(negedge Clk);
      Place = 1'b0;
      @(negedge Clk);
   endtask

   task automatic press_start;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      @(negedge Clk);
   endtask

   task automatic settle;
      int n = 0;
      while (Busy === 1'b1 && n < 20) begin
         @(negedge Clk);
         n++;
      end
   endtask

   task automatic test_reset;
      int cnt = 0;
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      n_tests++;
      if (State !== CLEAR || Busy !== 1'b1 || Move_count !== 8'd0 || Cat_row !== 3'd3 || Cat_col !== 3'd3) begin
         n_fail++;
         $display("FAIL reset_values: state=%0d busy=%0b mc=%0d cat=(%0d,%0d), expected 0 1 0 (3,3)", State, Busy, Move_count, Cat_row, Cat_col);
      end
      Reset = 1'b0;
      while (Busy === 1'b1 && cnt < 100) begin
         @(negedge Clk);
         cnt++;
      end
      n_tests++;
      if (cnt != 42) begin
         n_fail++;
         $display("FAIL reset_clear_len: %0d cycles, expected 42", cnt);
      end
      n_tests++;
      if (State !== IDLE || Move_count !== 8'd0 || Cat_row !== 3'd3 || Cat_col !== 3'd3) begin
         n_fail++;
         $display("FAIL reset_idle: state=%0d mc=%0d cat=(%0d,%0d), expected 1 0 (3,3)", State, Move_count, Cat_row, Cat_col);
      end
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 7; c++) begin
            Rd_row = 3'(r); Rd_col = 3'(c);
            #1;
            n_tests++;
            if (Rd_cell !== ((r == 3 && c == 3) ? 2'd2 : 2'd0)) begin
               n_fail++;
               $display("FAIL reset_board(%0d,%0d): got %0d expected %0d", r, c, Rd_cell, (r == 3 && c == 3) ? 2 : 0);
            end
         end
      end
      Rd_row = 3'd7; Rd_col = 3'd0;
      #1;
      n_tests++;
      if (Rd_cell !== 2'd3) begin
         n_fail++;
         $display("FAIL off_row7: got %0d expected 3", Rd_cell);
      end
      Rd_row = 3'd0; Rd_col = 3'd7;
      #1;
      n_tests++;
      if (Rd_cell !== 2'd3) begin
         n_fail++;
         $display("FAIL off_col7: got %0d expected 3", Rd_cell);
      end
   endtask

   task automatic test_restart(input string tag);
      int cnt = 0;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      while (Busy === 1'b1 && cnt < 100) begin
         @(negedge Clk);
         cnt++;
      end
      n_tests++;
      if (cnt != 42 || State !== IDLE || Move_count !== 8'd0 || Cat_row !== 3'd3 || Cat_col !== 3'd3) begin
         n_fail++;
         $display("FAIL restart_%s: cycles=%0d state=%0d mc=%0d cat=(%0d,%0d), expected 42 1 0 (3,3)", tag, cnt, State, Move_count, Cat_row, Cat_col);
      end
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 7; c++) begin
            Rd_row = 3'(r); Rd_col = 3'(c);
            #1;
            n_tests++;
            if (Rd_cell !== ((r == 3 && c == 3) ? 2'd2 : 2'd0)) begin
               n_fail++;
               $display("FAIL restart_%s_board(%0d,%0d): got %0d expected %0d", tag, r, c, Rd_cell, (r == 3 && c == 3) ? 2 : 0);
            end
         end
      end
   endtask

   task automatic test_play_timing;
      press_start();
      n_tests++;
      if (State !== PLAY) begin
         n_fail++;
         $display("FAIL start_to_play: state=%0d expected %0d", State, PLAY);
      end
      Sel_row = 3'd0; Sel_col = 3'd0; Place = 1'b1;
      @(negedge Clk);
      Rd_row = 3'd0; Rd_col = 3'd0;
      #1;
      n_tests++;
      if (Rd_cell !== 2'd1 || State !== MOVE || Busy !== 1'b1) begin
         n_fail++;
         $display("FAIL place_edge_t: cell=%0d state=%0d busy=%0b, expected 1 3 1", Rd_cell, State, Busy);
      end
      Place = 1'b0;
      @(negedge Clk);
      n_tests++;
      if (Cat_row !== 3'd4 || Cat_col !== 3'd3 || State !== PLAY || Move_count !== 8'd1) begin
         n_fail++;
         $display("FAIL move_d0: cat=(%0d,%0d) state=%0d mc=%0d, expected (4,3) 2 1", Cat_row, Cat_col, State, Move_count);
      end
      Sel_row = 3'd5; Sel_col = 3'd3; Place = 1'b1;
      @(negedge Clk);
      Place = 1'b0;
      @(negedge Clk);
      n_tests++;
      if (State !== MOVE || Cat_row !== 3'd4 || Cat_col !== 3'd3) begin
         n_fail++;
         $display("FAIL move_d0_blocked: state=%0d cat=(%0d,%0d), expected 3 (4,3)", State, Cat_row, Cat_col);
      end
      @(negedge Clk);
      n_tests++;
      if (State !== PLAY || Cat_row !== 3'd4 || Cat_col !== 3'd4 || Move_count !== 8'd2) begin
         n_fail++;
         $display("FAIL move_d1: state=%0d cat=(%0d,%0d) mc=%0d, expected 2 (4,4) 2", State, Cat_row, Cat_col, Move_count);
      end
      Rd_row = 3'd4; Rd_col = 3'd3;
      #1;
      n_tests++;
      if (Rd_cell !== 2'd0) begin
         n_fail++;
         $display("FAIL old_cat_cell: got %0d expected 0", Rd_cell);
      end
      Rd_row = 3'd4; Rd_col = 3'd4;
      #1;
      n_tests++;
      if (Rd_cell !== 2'd2) begin
         n_fail++;
         $display("FAIL new_cat_cell: got %0d expected 2", Rd_cell);
      end
   endtask

   task automatic test_illegal;
      step_t steps[$];
      step_t e;
      steps = '{mk(4, 4, PLAY, 4, 4, 2), mk(0, 0, PLAY, 4, 4, 2), mk(7, 0, PLAY, 4, 4, 2), mk(0, 7, PLAY, 4, 4, 2)};
      foreach (steps[i]) begin
         sb.push_back(steps[i]);
         press_place(steps[i].r, steps[i].c);
         settle();
         e = sb.pop_front();
         n_tests++;
         if (State !== e.st || Cat_row !== e.cr || Cat_col !== e.cc || Move_count !== e.mc) begin
            n_fail++;
            $display("FAIL illegal_%0d: state=%0d cat=(%0d,%0d) mc=%0d, expected %0d (%0d,%0d) %0d", i, State, Cat_row, Cat_col, Move_count, e.st, e.cr, e.cc, e.mc);
         end
      end
      press_start();
      n_tests++;
      if (State !== PLAY || Move_count !== 8'd2) begin
         n_fail++;
         $display("FAIL start_in_play: state=%0d mc=%0d, expected 2 2", State, Move_count);
      end
      sb.push_back(mk(1, 1, LOSE, 5, 4, 3));
      Sel_row = 3'd1; Sel_col = 3'd1; Place = 1'b1;
      repeat (10) @(negedge Clk);
      Place = 1'b0;
      @(negedge Clk);
      e = sb.pop_front();
      n_tests++;
      if (State !== e.st || Cat_row !== e.cr || Cat_col !== e.cc || Move_count !== e.mc) begin
         n_fail++;
         $display("FAIL held_place: state=%0d cat=(%0d,%0d) mc=%0d, expected %0d (%0d,%0d) %0d", State, Cat_row, Cat_col, Move_count, e.st, e.cr, e.cc, e.mc);
      end
      Rd_row = 3'd1; Rd_col = 3'd1;
      #1;
      n_tests++;
      if (Rd_cell !== 2'd1) begin
         n_fail++;
         $display("FAIL held_block_cell: got %0d expected 1", Rd_cell);
      end
   endtask

   task automatic test_lose;
      step_t steps[$];
      step_t e;
      press_start();
      steps = '{mk(0, 0, PLAY, 4, 3, 1), mk(0, 1, LOSE, 5, 3, 2)};
      foreach (steps[i]) begin
         sb.push_back(steps[i]);
         press_place(steps[i].r, steps[i].c);
         settle();
         e = sb.pop_front();
         n_tests++;
         if (State !== e.st || Cat_row !== e.cr || Cat_col !== e.cc || Move_count !== e.mc) begin
            n_fail++;
            $display("FAIL lose_%0d: state=%0d cat=(%0d,%0d) mc=%0d, expected %0d (%0d,%0d) %0d", i, State, Cat_row, Cat_col, Move_count, e.st, e.cr, e.cc, e.mc);
         end
      end
   endtask

   task automatic test_win;
      step_t steps[$];
      step_t e;
      int cnt = 0;
      steps = '{mk(2, 3, IDLE, 3, 3, 0), mk(3, 4, IDLE, 3, 3, 0), mk(3, 2, IDLE, 3, 3, 0)};
      foreach (steps[i]) begin
         sb.push_back(steps[i]);
         press_place(steps[i].r, steps[i].c);
         settle();
         e = sb.pop_front();
         n_tests++;
         if (State !== e.st || Cat_row !== e.cr || Cat_col !== e.cc || Move_count !== e.mc) begin
            n_fail++;
            $display("FAIL idle_place_%0d: state=%0d cat=(%0d,%0d) mc=%0d, expected %0d (%0d,%0d) %0d", i, State, Cat_row, Cat_col, Move_count, e.st, e.cr, e.cc, e.mc);
         end
         Rd_row = steps[i].r; Rd_col = steps[i].c;
         #1;
         n_tests++;
         if (Rd_cell !== 2'd1) begin
            n_fail++;
            $display("FAIL idle_block_cell_%0d: got %0d expected 1", i, Rd_cell);
         end
      end
      press_start();
      sb.push_back(mk(4, 3, WIN, 3, 3, 1));
      Sel_row = 3'd4; Sel_col = 3'd3; Place = 1'b1;
      @(negedge Clk);
      Place = 1'b0;
      while (Busy === 1'b1 && cnt < 20) begin
         @(negedge Clk);
         cnt++;
      end
      e = sb.pop_front();
      n_tests++;
      if (cnt != 4 || State !== e.st || Cat_row !== e.cr || Cat_col !== e.cc || Move_count !== e.mc) begin
         n_fail++;
         $display("FAIL win: move_cycles=%0d state=%0d cat=(%0d,%0d) mc=%0d, expected 4 %0d (%0d,%0d) %0d", cnt, State, Cat_row, Cat_col, Move_count, e.st, e.cr, e.cc, e.mc);
      end
   endtask

   task automatic test_simultaneous;
      Sel_row = 3'd1; Sel_col = 3'd1;
      Start = 1'b1; Place = 1'b1;
      @(negedge Clk);
      Start = 1'b0; Place = 1'b0;
      @(negedge Clk);
      Rd_row = 3'd1; Rd_col = 3'd1;
      #1;
      n_tests++;
      if (State !== PLAY || Rd_cell !== 2'd0 || Move_count !== 8'd0) begin
         n_fail++;
         $display("FAIL start_beats_place: state=%0d cell=%0d mc=%0d, expected 2 0 0", State, Rd_cell, Move_count);
      end
   endtask

   task automatic test_reset_mid_move;
      int cnt = 0;
      Sel_row = 3'd4; Sel_col = 3'd3; Place = 1'b1;
      @(negedge Clk);
      Place = 1'b0;
      @(negedge Clk);
      n_tests++;
      if (State !== MOVE || Move_count !== 8'd1) begin
         n_fail++;
         $display("FAIL pre_reset_move: state=%0d mc=%0d, expected 3 1", State, Move_count);
      end
      #2 Reset = 1'b1;
      #1;
      n_tests++;
      if (State !== CLEAR || Busy !== 1'b1 || Move_count !== 8'd0 || Cat_row !== 3'd3 || Cat_col !== 3'd3) begin
         n_fail++;
         $display("FAIL async_reset_move: state=%0d busy=%0b mc=%0d cat=(%0d,%0d), expected 0 1 0 (3,3)", State, Busy, Move_count, Cat_row, Cat_col);
      end
      @(negedge Clk);
      Reset = 1'b0;
      while (Busy === 1'b1 && cnt < 100) begin
         @(negedge Clk);
         cnt++;
      end
      n_tests++;
      if (cnt != 42 || State !== IDLE) begin
         n_fail++;
         $display("FAIL post_reset_clear: cycles=%0d state=%0d, expected 42 1", cnt, State);
      end
   endtask

   initial begin
      test_reset();
      test_play_timing();
      test_illegal();
      test_restart("lose");
      test_lose();
      test_restart("lose2");
      test_win();
      test_restart("win");
      test_simultaneous();
      test_reset_mid_move();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/cat_trap_engine.md
Name: cat_trap_engine

Overview:
Parametrised game engine for the Cat Trap VGA game: an ROWS x COLS board, a cat that moves one cell after every accepted block placement, and start/play/win/lose sequencing. Successor to the fixed 6x7 engine, with three additions: edge-detected buttons, a multi-cycle neighbour probe, and an IDLE-mode obstacle setup phase. The board clears itself by sweeping one cell per clock, so the storage array needs no reset. Sits between the debounced button/switch front end and the pixel renderer. The renderer reads cells through a combinational read port.

Parameters:
ROWS, 6, board rows (>=3)
COLS, 7, board columns (>=3)
CNT_W, 8, width of Move_count
ROW_W, $clog2(ROWS), row index width (derived)
COL_W, $clog2(COLS), column index width (derived)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  debounced level; rising edge = start/restart
Place  in  1  debounced level; rising edge = place block at Sel
Sel_row  in  ROW_W  target row, binary
Sel_col  in  COL_W  target column, binary
Rd_row  in  ROW_W  renderer read row
Rd_col  in  COL_W  renderer read column
Rd_cell  out  2  cell code at (Rd_row,Rd_col), combinational; 3 if out of range
State  out  3  game state encoding (from package)
Cat_row  out  ROW_W  cat row
Cat_col  out  COL_W  cat column
Move_count  out  CNT_W  accepted in-game placements, saturating
Busy  out  1  high in CLEAR and MOVE

Behaviour:
- Reset is asynchronous, active-high; clock is Clk.
- Reset values:
  - State=CLEAR, clear index=0, Cat=(ROWS/2, COLS/2), Move_count=0, Busy=1.
  - Edge-detector history registers = 0.
  - Board array is not reset.
- Cell codes: 0 EMPTY, 1 BLOCK, 2 CAT, 3 OFF (read port only).
- Edges: a rising edge is the input high this cycle and low in the registered history. One action per edge, even if the input is held.
- CLEAR:
  - Writes EMPTY to cell idx (row-major) each cycle.
  - On the last cell (ROWS*COLS-1): writes CAT at the centre, sets Cat=(ROWS/2, COLS/2), Move_count=0, then goes to IDLE.
  - Duration: exactly ROWS*COLS cycles.
- IDLE:
  - Place edge with Sel in range and the cell EMPTY -> cell=BLOCK. No cat move, Move_count unchanged.
  - Start edge -> PLAY.
  - If Place and Start edges arrive in the same cycle, Start wins and the Place is dropped.
- PLAY:
  - Place edge with Sel in range and the cell EMPTY, detected at edge t: at t, cell=BLOCK, Move_count++ (saturating), State=MOVE, dir=0.
  - Place edge on a BLOCK cell, the CAT cell, or an out-of-range Sel -> ignored; no state change.
  - Start edges are ignored in PLAY.
- MOVE: at edge t+1+d, probe neighbour d in this order:
  - d=0: (r+1, c)
  - d=1: (r, c+1)
  - d=2: (r-1, c)
  - d=3: (r, c-1)
- MOVE outcome per probe:
  - If the neighbour is EMPTY: old cell=EMPTY, new cell=CAT, Cat updated.
    - If the new position is on the border (row 0, row ROWS-1, col 0 or col COLS-1) -> LOSE, otherwise -> PLAY.
  - If all four neighbours are non-EMPTY: State=WIN at edge t+4.
  - Neighbours are always in range, because the cat is interior throughout PLAY/MOVE.
  - Place/Start edges during MOVE are dropped; the history register still updates.
- WIN / LOSE: hold the board. Start edge -> CLEAR (full sweep, Move_count reset).
- Reset mid-operation (any state, including MOVE/CLEAR) -> CLEAR immediately, with the reset values above.
- Rd_cell reflects the board array directly; contents are valid only after the first CLEAR completes.

Decomposition:
- Package cat_trap_pkg holds:
  - cell code constants EMPTY/BLOCK/CAT/OFF
  - state encoding CLEAR/IDLE/PLAY/MOVE/WIN/LOSE
  - direction order constants
- Sub-module btn_edge (1-bit rising-edge detector, async reset): one instance each for Start and Place.

Test Plan:
- Default 6x7: Reset pulse -> Busy=1 for 42 cycles, then State=IDLE, Cat=(3,3), Rd_cell(3,3)=2, every other cell 0, Rd_cell(row 7, col 0)=3, Move_count=0.
- Start edge, then Place (0,0) -> next edge Rd_cell(0,0)=1; one cycle later Cat=(4,3), State=PLAY, Move_count=1. Then Place (5,3) -> d0 blocked; Cat=(4,4) two cycles after MOVE entry.
- Lose: from fresh IDLE, Start, Place (0,0) -> Cat=(4,3); Place (0,1) -> Cat=(5,3), State=LOSE, Move_count=2.
- Win: in IDLE, Place (2,3), (3,4), (3,2) -> all BLOCK, Move_count=0. Start, Place (4,3) -> four MOVE cycles, State=WIN, Cat=(3,3), Move_count=1.
- Illegal places in PLAY:
  - (3,3) on the cat -> ignored.
  - A repeat of an existing BLOCK -> ignored.
  - Sel_row=7 -> ignored.
  - Place held high for 10 cycles -> a single action.
  - In every case: Move_count and Cat unchanged except for the one legal action.
- Restart and reset:
  - Start edge in LOSE -> 42-cycle CLEAR, board all EMPTY except the centre CAT, Move_count=0.
  - Reset asserted during MOVE d=1 -> State=CLEAR asynchronously.
